mt9v034_serializer_tx: RTL and testbench
========================================

MT9V034_SERIALIZER_TX -- requirements
Module: mt9v034_serializer_tx

Interface
REQ-001 Parameter STEREO_MODE, default 1: 1 = 18-bit stereo word (start, 8 bits ch1, 8 bits ch2, stop); 0 = 12-bit mono word (start, 10 payload bits, stop).
REQ-002 Parameter IDLE_CODE, default 8'h00: blanking/idle payload byte per channel.
REQ-003 TxClk  input  1  bit-rate clock; the only clock; all logic on its rising edge.
REQ-004 Reset  input  1  asynchronous, active-high reset.
REQ-005 vid_valid  input  1  input word valid.
REQ-006 vid_ready  output  1  block can accept a word; transfer occurs when vid_valid && vid_ready.
REQ-007 vid_data  input  8  channel-1 pixel.
REQ-008 vid2_data  input  8  channel-2 pixel; ignored when STEREO_MODE=0.
REQ-009 vid_active_video  input  1  word is an active pixel.
REQ-010 vid_vblank  input  1  word lies in vertical blanking.
REQ-011 ser_out  output  1  serial stream toward the LVDS output buffer.
REQ-012 underrun  output  1  one-cycle pulse when an idle word is sent for lack of input.
REQ-013 underrun_count  output  16  saturating underrun counter; present only with TX_UNDERRUN_CNT_EN.

Function
REQ-014 Word length W = 18 (STEREO_MODE=1) or 12 (0); bit counter runs 0..W-1, wrapping; a new word loads into the shift register at wrap (boundary).
REQ-015 Bit order: start bit 1, channel-1 payload LSB first, channel-2 payload LSB first (stereo), stop bit 0.
REQ-016 Mono payload: bits[7:0] = channel-1 byte, bits[9:8] = 2'b00.
REQ-017 One-entry holding register; vid_ready = !hold_valid || (boundary && hold consumed this cycle and no sync pending).
REQ-018 Active pixel bytes are clipped: 8'h00 -> 8'h01, 8'hFF -> 8'hFE; a blanking word (vid_active_video=0) sends IDLE_CODE on all channels.
REQ-019 Sync FSM states: BLANK, ACTIVE, SYNC1, SYNC2, SYNC3; codes are identical on both channels.
REQ-020 BLANK -> held word active: emit three sync words before it; frame start FF,00,FF if previous blanking word had vid_vblank=1 or the block is fresh out of reset; otherwise line start FF,00,00.
REQ-021 ACTIVE -> held word blanking: emit line end FF,FF,FF, or frame end FF,FF,00 when that word has vid_vblank=1, then the word; FSM -> BLANK.
REQ-022 Held word is consumed only at the boundary after SYNC3 or directly in the same state (no sync needed); it is never dropped or duplicated.
REQ-023 At a boundary with no held word and no sync pending: send IDLE_CODE word, pulse underrun, FSM state unchanged.
REQ-024 Latency: start bit of an accepted word (no sync pending) appears on ser_out at most W+1 cycles after acceptance.
REQ-025 vid_valid deasserted mid-sync sequence does not abort the sequence.

Reset
REQ-026 While Reset=1: ser_out=0, vid_ready=0, underrun=0, underrun_count=0, hold_valid=0, bit counter=0, FSM=BLANK with frame-start flag set.
REQ-027 First boundary after Reset falls occurs W cycles later; vid_ready=1 from the first cycle after release.
REQ-028 Reset asserted mid-word truncates the word immediately; no partial word resumes.

Configuration
REQ-029 Macro TX_UNDERRUN_CNT_EN defined: underrun_count port exists, increments on each underrun pulse, saturates at 16'hFFFF.
REQ-030 Macro TX_UNDERRUN_CNT_EN undefined: port and counter absent; underrun pulse unchanged.

Verification
REQ-031 Reset, no input, STEREO_MODE=1 -> ser_out repeats 1,0x16,0 every 18 cycles; underrun pulses every 18 cycles; count = 3 after 3 words.
REQ-032 After reset, stream one active word 8'h12/8'h34 -> words FF,00,FF (frame start) then 12/34 LSB first on ser_out.
REQ-033 Active 8'h00/8'hFF -> transmitted as 01/FE.
REQ-034 Active line then blanking with vblank=0 -> LE FF,FF,FF; next active -> LS FF,00,00; blanking with vblank=1 -> FE FF,FF,00, next active -> FS.
REQ-035 STEREO_MODE=0, active 8'hA5 -> 12-bit words 1, A5 LSB first, 00, 0; bits on ser_out match.
REQ-036 Hold vid_valid=1 continuously for 1000 words -> no underrun; ready/valid count equals words emitted minus sync words.

Source files
------------

// File: rtl/mt9v034_serializer_tx.sv
// Serializer for the MT9V034 LVDS stream: framed words with line/frame sync insertion.
// Define TX_UNDERRUN_CNT_EN to add the saturating underrun_count output.
module mt9v034_serializer_tx #(
  parameter int unsigned STEREO_MODE = 1,
  parameter logic [7:0]  IDLE_CODE   = 8'h00
) (
  input  logic       TxClk,
  input  logic       Reset,
  input  logic       vid_valid,
  output logic       vid_ready,
  input  logic [7:0] vid_data,
  input  logic [7:0] vid2_data,
  input  logic       vid_active_video,
  input  logic       vid_vblank,
  output logic       ser_out,
  output logic       underrun
`ifdef TX_UNDERRUN_CNT_EN
  ,
  output logic [15:0] underrun_count
`endif
);

  localparam int unsigned W        = (STEREO_MODE != 0) ? 18 : 12;
  localparam logic [4:0]  LAST_BIT = 5'(W - 1);

  typedef enum logic [2:0] {StBlank, StActive, StSync1, StSync2, StSync3} state_e;
  typedef enum logic [1:0] {SyFrameStart, SyLineStart, SyLineEnd, SyFrameEnd} sync_e;

  state_e      r_state, w_state_d;
  sync_e       r_sync, w_sync_d;
  logic [4:0]  r_bit_cnt;
  logic [17:0] r_shift;
  logic        r_hold_valid, r_hold_act, r_hold_vb;
  logic [7:0]  r_hold_d1, r_hold_d2;
  logic        r_frame_start;
  logic        r_underrun;

  logic        w_boundary, w_consume, w_underrun_d, w_accept;
  logic [7:0]  w_pay1, w_pay2, w_held1, w_held2;
  logic [17:0] w_word;

  // Active pixels must never collide with the 00/FF sync codes.
  function automatic logic [7:0] clip_px(input logic [7:0] px);
    if (px == 8'h00) return 8'h01;
    if (px == 8'hFF) return 8'hFE;
    return px;
  endfunction

  assign w_boundary = (r_bit_cnt == LAST_BIT);
  assign w_accept   = vid_valid && vid_ready;
  assign vid_ready  = !Reset && (!r_hold_valid || w_consume);
  assign w_held1    = r_hold_act ? clip_px(r_hold_d1) : IDLE_CODE;
  assign w_held2    = r_hold_act ? clip_px(r_hold_d2) : IDLE_CODE;

  always_ff @(posedge TxClk or posedge Reset) begin
    if (Reset) begin
      r_state <= StBlank;
      r_sync  <= SyFrameStart;
    end else begin
      r_state <= w_state_d;
      r_sync  <= w_sync_d;
    end
  end

  always_comb begin
    w_state_d = r_state;
    w_sync_d  = r_sync;
    if (w_boundary) begin
      unique case (r_state)
        StBlank: begin
          if (r_hold_valid && r_hold_act) begin
            w_state_d = StSync1;
            w_sync_d  = r_frame_start ? SyFrameStart : SyLineStart;
          end
        end
        StActive: begin
          if (r_hold_valid && !r_hold_act) begin
            w_state_d = StSync1;
            w_sync_d  = r_hold_vb ? SyFrameEnd : SyLineEnd;
          end
        end
        StSync1: w_state_d = StSync2;
        StSync2: w_state_d = StSync3;
        StSync3: w_state_d = r_hold_act ? StActive : StBlank;
        default: w_state_d = StBlank;
      endcase
    end
  end

  always_comb begin
    w_consume    = 1'b0;
    w_underrun_d = 1'b0;
    w_pay1       = IDLE_CODE;
    w_pay2       = IDLE_CODE;
    if (w_boundary) begin
      unique case (r_state)
        StBlank, StActive: begin
          if (!r_hold_valid) begin
            w_underrun_d = 1'b1;
          end else if (r_hold_act == (r_state == StActive)) begin
            w_consume = 1'b1;
            w_pay1    = w_held1;
            w_pay2    = w_held2;
          end else begin
            w_pay1 = 8'hFF;
            w_pay2 = 8'hFF;
          end
        end
        StSync1: begin
          w_pay1 = (r_sync == SyLineEnd || r_sync == SyFrameEnd) ? 8'hFF : 8'h00;
          w_pay2 = w_pay1;
        end
        StSync2: begin
          w_pay1 = (r_sync == SyFrameStart || r_sync == SyLineEnd) ? 8'hFF : 8'h00;
          w_pay2 = w_pay1;
        end
        StSync3: begin
          w_consume = 1'b1;
          w_pay1    = w_held1;
          w_pay2    = w_held2;
        end
        default: ;
      endcase
    end
  end

  // Bit 0 goes out first: start bit, ch1 LSB first, ch2 LSB first, stop bit.
  assign w_word = (STEREO_MODE != 0) ? {1'b0, w_pay2, w_pay1, 1'b1}
                                     : {6'b0, 1'b0, 2'b00, w_pay1, 1'b1};

  always_ff @(posedge TxClk or posedge Reset) begin
    if (Reset) begin
      r_bit_cnt     <= '0;
      r_shift       <= '0;
      r_underrun    <= 1'b0;
      r_hold_valid  <= 1'b0;
      r_hold_act    <= 1'b0;
      r_hold_vb     <= 1'b0;
      r_hold_d1     <= '0;
      r_hold_d2     <= '0;
      r_frame_start <= 1'b1;
    end else begin
      r_bit_cnt  <= w_boundary ? 5'd0 : r_bit_cnt + 5'd1;
      r_shift    <= w_boundary ? w_word : {1'b0, r_shift[17:1]};
      r_underrun <= w_underrun_d;
      if (w_accept) begin
        r_hold_valid <= 1'b1;
        r_hold_act   <= vid_active_video;
        r_hold_vb    <= vid_vblank;
        r_hold_d1    <= vid_data;
        r_hold_d2    <= vid2_data;
      end else if (w_consume) begin
        r_hold_valid <= 1'b0;
      end
      if (w_consume) r_frame_start <= r_hold_act ? 1'b0 : r_hold_vb;
    end
  end

  assign ser_out  = r_shift[0];
  assign underrun = r_underrun;

`ifdef TX_UNDERRUN_CNT_EN
  logic [15:0] r_underrun_cnt;

  always_ff @(posedge TxClk or posedge Reset) begin
    if (Reset) begin
      r_underrun_cnt <= '0;
    end else if (w_underrun_d && (r_underrun_cnt != 16'hFFFF)) begin
      r_underrun_cnt <= r_underrun_cnt + 16'd1;
    end
  end

  assign underrun_count = r_underrun_cnt;
`endif

endmodule

// File: tb/tb_mt9v034_serializer_tx.sv
// Randomized bench: stereo and mono instances, serial stream decoded into words and compared
// against a transaction-level model of sync insertion, clipping and idle fill.
module tb_mt9v034_serializer_tx;

  typedef struct packed {
    logic       a;
    logic       v;
    logic [7:0] b1;
    logic [7:0] b2;
  } item_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       vv [2];
  logic       vr [2];
  logic       act [2];
  logic       vb [2];
  logic       so [2];
  logic       un [2];
  logic [7:0] d1 [2];
  logic [7:0] d2 [2];
`ifdef TX_UNDERRUN_CNT_EN
  logic [15:0] ucnt [2];
`endif

  always #5 clk = ~clk;

  mt9v034_serializer_tx #(.STEREO_MODE(1), .IDLE_CODE(8'h00)) u_dut_stereo (
    .TxClk(clk), .Reset(rst), .vid_valid(vv[0]), .vid_ready(vr[0]), .vid_data(d1[0]),
    .vid2_data(d2[0]), .vid_active_video(act[0]), .vid_vblank(vb[0]), .ser_out(so[0]),
    .underrun(un[0])
`ifdef TX_UNDERRUN_CNT_EN
    , .underrun_count(ucnt[0])
`endif
  );

  mt9v034_serializer_tx #(.STEREO_MODE(0), .IDLE_CODE(8'h3C)) u_dut_mono (
    .TxClk(clk), .Reset(rst), .vid_valid(vv[1]), .vid_ready(vr[1]), .vid_data(d1[1]),
    .vid2_data(d2[1]), .vid_active_video(act[1]), .vid_vblank(vb[1]), .ser_out(so[1]),
    .underrun(un[1])
`ifdef TX_UNDERRUN_CNT_EN
    , .underrun_count(ucnt[1])
`endif
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
  endtask

  // Reference model state
  bit          m_in_act [2];
  bit          m_frame [2];
  logic [17:0] exp_q0[$];
  logic [17:0] exp_q1[$];
  item_t       cur [2];
  item_t       dir_items [8];
  int          dir_idx [2];
  bit          took [2];
  int          acc_cnt [2];
  // Decoder state
  int          ncyc [2];
  int          und_total [2];
  logic [17:0] acc [2];
  bit          uflag [2];

  function automatic int wlen(input int l);
    return (l == 0) ? 18 : 12;
  endfunction

  function automatic logic [7:0] idle_of(input int l);
    return (l == 0) ? 8'h00 : 8'h3C;
  endfunction

  function automatic logic [17:0] mk_frame(input int l, input logic [7:0] p1,
                                           input logic [7:0] p2);
    if (l == 0) return {1'b0, p2, p1, 1'b1};
    return {6'b0, 1'b0, 2'b00, p1, 1'b1};
  endfunction

  function automatic logic [7:0] clip(input logic [7:0] b);
    if (b == 8'h00) return 8'h01;
    if (b == 8'hFF) return 8'hFE;
    return b;
  endfunction

  function automatic item_t mk_item(input logic a, input logic v, input logic [7:0] b1,
                                    input logic [7:0] b2);
    item_t it;
    it.a = a; it.v = v; it.b1 = b1; it.b2 = b2;
    return it;
  endfunction

  function automatic logic [7:0] pick_byte();
    int r;
    r = $urandom_range(0, 7);
    if (r == 0) return 8'h00;
    if (r == 1) return 8'hFF;
    return 8'($urandom());
  endfunction

  task automatic push_exp(input int l, input logic [17:0] f);
    if (l == 0) exp_q0.push_back(f);
    else exp_q1.push_back(f);
  endtask

  task automatic push_sync(input int l, input logic [7:0] c1, input logic [7:0] c2,
                           input logic [7:0] c3);
    push_exp(l, mk_frame(l, c1, c1));
    push_exp(l, mk_frame(l, c2, c2));
    push_exp(l, mk_frame(l, c3, c3));
  endtask

  task automatic model_accept(input int l, input item_t it);
    if (it.a) begin
      if (!m_in_act[l]) push_sync(l, 8'hFF, 8'h00, m_frame[l] ? 8'hFF : 8'h00);
      m_in_act[l] = 1'b1;
      m_frame[l]  = 1'b0;
      push_exp(l, mk_frame(l, clip(it.b1), clip(it.b2)));
    end else begin
      if (m_in_act[l]) push_sync(l, 8'hFF, 8'hFF, it.v ? 8'h00 : 8'hFF);
      m_in_act[l] = 1'b0;
      m_frame[l]  = it.v;
      push_exp(l, mk_frame(l, idle_of(l), idle_of(l)));
    end
  endtask

  task automatic finish_word(input int l, input logic [17:0] f, input bit u);
    logic [17:0] e;
    if (u) begin
      check_eq((l == 0) ? "stereo_idle" : "mono_idle", f, mk_frame(l, idle_of(l), idle_of(l)));
    end else begin
      e = 18'h3FFFF;
      if (l == 0 && exp_q0.size() != 0) e = exp_q0.pop_front();
      if (l == 1 && exp_q1.size() != 0) e = exp_q1.pop_front();
      check_eq((l == 0) ? "stereo_word" : "mono_word", f, e);
    end
  endtask

  // Words start on the W-th cycle after reset release and repeat every W cycles.
  task automatic collect(input int l);
    int w;
    int idx;
    w = wlen(l);
    ncyc[l]++;
    if (un[l]) und_total[l]++;
    if (ncyc[l] >= w) begin
      idx = (ncyc[l] - w) % w;
      if (idx == 0) begin
        acc[l]   = '0;
        uflag[l] = un[l];
      end
      acc[l][idx] = so[l];
      if (idx == w - 1) finish_word(l, acc[l], uflag[l]);
    end
  endtask

  task automatic next_item(input int l, output item_t it);
    if (dir_idx[l] < 8) begin
      it = dir_items[dir_idx[l]];
      dir_idx[l]++;
    end else begin
      it = mk_item(($urandom_range(0, 9) != 0), 1'($urandom_range(0, 1)), pick_byte(),
                   pick_byte());
    end
  endtask

  task automatic tick(input bit gen_en, input bit stream);
    @(negedge clk);
    for (int l = 0; l < 2; l++) collect(l);
    for (int l = 0; l < 2; l++) begin
      if (!(vv[l] && !took[l])) begin
        if (gen_en && (stream || $urandom_range(0, 2) != 0)) begin
          next_item(l, cur[l]);
          vv[l] = 1'b1;
        end else begin
          vv[l] = 1'b0;
        end
      end
      act[l] = cur[l].a;
      vb[l]  = cur[l].v;
      d1[l]  = cur[l].b1;
      d2[l]  = cur[l].b2;
    end
    #1;
    for (int l = 0; l < 2; l++) begin
      took[l] = vv[l] && vr[l];
      if (took[l]) begin
        model_accept(l, cur[l]);
        acc_cnt[l]++;
      end
    end
  endtask

  task automatic clear_state();
    for (int l = 0; l < 2; l++) begin
      m_in_act[l] = 1'b0; m_frame[l] = 1'b1; took[l] = 1'b0; vv[l] = 1'b0;
      ncyc[l] = 0; und_total[l] = 0; acc[l] = '0; uflag[l] = 1'b0;
    end
    exp_q0.delete();
    exp_q1.delete();
  endtask

  initial begin
    int cyc;
    int base [2];
    dir_items[0] = mk_item(1'b1, 1'b0, 8'h12, 8'h34);
    dir_items[1] = mk_item(1'b1, 1'b0, 8'h00, 8'hFF);
    dir_items[2] = mk_item(1'b1, 1'b0, 8'hA5, 8'h5A);
    dir_items[3] = mk_item(1'b0, 1'b0, 8'h77, 8'h77);
    dir_items[4] = mk_item(1'b1, 1'b0, 8'h55, 8'hAA);
    dir_items[5] = mk_item(1'b0, 1'b1, 8'h66, 8'h66);
    dir_items[6] = mk_item(1'b0, 1'b1, 8'h11, 8'h22);
    dir_items[7] = mk_item(1'b1, 1'b0, 8'hA5, 8'hC3);
    for (int l = 0; l < 2; l++) begin
      cur[l] = '0; dir_idx[l] = 0; acc_cnt[l] = 0;
      act[l] = 1'b0; vb[l] = 1'b0; d1[l] = '0; d2[l] = '0;
    end
    clear_state();

    rst = 1'b1;
    repeat (3) @(negedge clk);
    for (int l = 0; l < 2; l++) begin
      check_eq("rst_ser_out", so[l], 1'b0);
      check_eq("rst_ready", vr[l], 1'b0);
      check_eq("rst_underrun", un[l], 1'b0);
`ifdef TX_UNDERRUN_CNT_EN
      check_eq("rst_underrun_count", ucnt[l], 16'd0);
`endif
    end
    #2 rst = 1'b0;
    #1;
    for (int l = 0; l < 2; l++) check_eq("ready_after_release", vr[l], 1'b1);

    repeat (60) tick(1'b0, 1'b0);
    check_eq("idle_underruns_stereo", und_total[0], 3);
    check_eq("idle_underruns_mono", und_total[1], 5);
`ifdef TX_UNDERRUN_CNT_EN
    check_eq("underrun_count_stereo", ucnt[0], 16'd3);
    check_eq("underrun_count_mono", ucnt[1], 16'd5);
`endif

    cyc = 0;
    while (acc_cnt[0] < 150 && cyc < 15000) begin
      tick(1'b1, 1'b0);
      cyc++;
    end
    check_eq("gappy_accepts", acc_cnt[0], 150);

    repeat (36) tick(1'b1, 1'b1);
    base[0] = und_total[0];
    base[1] = und_total[1];
    cyc = 0;
    while (acc_cnt[0] < 1186 && cyc < 60000) begin
      tick(1'b1, 1'b1);
      cyc++;
    end
    check_eq("stream_accepts", acc_cnt[0], 1186);
    check_eq("stream_no_underrun_stereo", und_total[0] - base[0], 0);
    check_eq("stream_no_underrun_mono", und_total[1] - base[1], 0);

    repeat (16 * 18) tick(1'b0, 1'b0);
    check_eq("drain_stereo", exp_q0.size(), 0);
    check_eq("drain_mono", exp_q1.size(), 0);
`ifdef TX_UNDERRUN_CNT_EN
    check_eq("final_count_stereo", ucnt[0], 16'(und_total[0]));
    check_eq("final_count_mono", ucnt[1], 16'(und_total[1]));
`endif

    cyc = 0;
    while (so[0] !== 1'b1 && cyc < 40) begin
      tick(1'b0, 1'b0);
      cyc++;
    end
    check_eq("start_bit_seen", so[0], 1'b1);
    rst = 1'b1;
    #1;
    for (int l = 0; l < 2; l++) begin
      check_eq("midword_rst_ser_out", so[l], 1'b0);
      check_eq("midword_rst_ready", vr[l], 1'b0);
    end
    @(negedge clk);
    @(negedge clk);
    #2 rst = 1'b0;
    clear_state();
    repeat (54) tick(1'b0, 1'b0);
    check_eq("post_reset_underruns_stereo", und_total[0], 3);
    check_eq("post_reset_underruns_mono", und_total[1], 4);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
